// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain (decode .. writeback) with stall/bubble,
// per-stage flush, per-stage payload replacement on advance, and wrap-around
// stall/flush/retire performance counters.
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32,
    localparam int SEL_W = $clog2(STAGES + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       in_ready,
    input  logic                       stall_en,
    input  logic [SEL_W-1:0]           stall_at,
    input  logic [STAGES-1:0]          flush_mask,
    input  logic [STAGES-1:0]          upd_en,
    input  logic [STAGES*DATA_W-1:0]   upd_data,
    output logic [STAGES-1:0]          st_valid,
    output logic [STAGES*DATA_W-1:0]   st_data,
    output logic [STAGES*CTRL_W-1:0]   st_ctrl,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic [CNT_W-1:0]           retire_cnt
);

    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [CTRL_W-1:0] ctrl_q [STAGES];

    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [CTRL_W-1:0] src_ctrl [STAGES];

    logic [STAGES-1:0] clr_stage;
    logic [STAGES-1:0] hold_stage;

    logic frozen;
    logic retire_evt;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] retire_q;

    // The last stage has no successor, so its replacement slot is never used.
    logic unused_upd;
    assign unused_upd = upd_en[STAGES-1] ^ (^upd_data[(STAGES-1)*DATA_W +: DATA_W]);

    // Decide per stage: clear (flush or bubble), hold (upstream of stall point), or advance.
    always_comb begin
        clr_stage  = '0;
        hold_stage = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) begin
                clr_stage[k] = 1'b1;
            end else if (stall_en && (stall_at > SEL_W'(k))) begin
                hold_stage[k] = 1'b1;
            end else if (stall_en && (stall_at == SEL_W'(k))) begin
                clr_stage[k] = 1'b1;
            end
        end
    end

    // Value each stage takes when it advances; payload may be replaced on the way.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_ctrl[0]  = in_ctrl;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_ctrl[k]  = ctrl_q[k-1];
            src_data[k]  = upd_en[k-1] ? upd_data[(k-1)*DATA_W +: DATA_W] : data_q[k-1];
        end
    end

    // Stage registers: cleared stages load an all-zero no-op, held stages keep content.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                ctrl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (clr_stage[k]) begin
                    valid_q[k] <= 1'b0;
                    data_q[k]  <= '0;
                    ctrl_q[k]  <= '0;
                end else if (!hold_stage[k]) begin
                    valid_q[k] <= src_valid[k];
                    data_q[k]  <= src_data[k];
                    ctrl_q[k]  <= src_ctrl[k];
                end
            end
        end
    end

    // A stall point at or beyond the chain length freezes every stage; nothing retires then.
    assign frozen     = stall_en && (stall_at >= SEL_W'(STAGES));
    assign retire_evt = valid_q[STAGES-1] && !frozen;

    // Performance counters wrap naturally; a clear request wins over any increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            flush_q  <= '0;
            retire_q <= '0;
        end else if (cnt_clr) begin
            stall_q  <= '0;
            flush_q  <= '0;
            retire_q <= '0;
        end else begin
            if (stall_en) begin
                stall_q <= stall_q + 1'b1;
            end
            if (|flush_mask) begin
                flush_q <= flush_q + 1'b1;
            end
            if (retire_evt) begin
                retire_q <= retire_q + 1'b1;
            end
        end
    end

    assign in_ready   = !stall_en;
    assign st_valid   = valid_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign retire_cnt = retire_q;

    // Flatten the per-stage registers onto the packed output buses.
    always_comb begin
        st_data = '0;
        st_ctrl = '0;
        for (int k = 0; k < STAGES; k++) begin
            st_data[k*DATA_W +: DATA_W] = data_q[k];
            st_ctrl[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: stage snapshots are checked after each
// edge, and a scoreboard of expected retiring entries is compared by a
// separate monitor whenever an entry leaves the last stage.
module tb_pipe_stage_chain;

    localparam int STAGES = 4;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic                     clock;
    logic                     reset;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic [CTRL_W-1:0]        in_ctrl;
    logic                     in_ready;
    logic                     stall_en;
    logic [2:0]               stall_at;
    logic [STAGES-1:0]        flush_mask;
    logic [STAGES-1:0]        upd_en;
    logic [STAGES*DATA_W-1:0] upd_data;
    logic [STAGES-1:0]        st_valid;
    logic [STAGES*DATA_W-1:0] st_data;
    logic [STAGES*CTRL_W-1:0] st_ctrl;
    logic                     cnt_clr;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         flush_cnt;
    logic [CNT_W-1:0]         retire_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipe_stage_chain #(
        .STAGES(STAGES),
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_ready  (in_ready),
        .stall_en  (stall_en),
        .stall_at  (stall_at),
        .flush_mask(flush_mask),
        .upd_en    (upd_en),
        .upd_data  (upd_data),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_ctrl   (st_ctrl),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .retire_cnt(retire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] ctrl_of(input logic [31:0] d);
        return d[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] entry(input int i);
        return 32'h100 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] sd(input int k);
        return st_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [31:0] sc(input int k);
        return {16'h0, st_ctrl[k*CTRL_W +: CTRL_W]};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic stall,
                                 input logic [2:0] at, input logic [3:0] flush,
                                 input logic [3:0] upd, input logic [31:0] upd_word,
                                 input logic clr);
        in_valid   = v;
        in_data    = d;
        in_ctrl    = ctrl_of(d);
        stall_en   = stall;
        stall_at   = at;
        flush_mask = flush;
        upd_en     = upd;
        upd_data   = {4{upd_word}};
        cnt_clr    = clr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.ctrl = ctrl_of(d);
        sb.push_back(e);
    endtask

    // Monitor: an entry leaves the last stage on the next edge unless the chain is frozen.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && st_valid[3] && !(stall_en && stall_at >= 3'd4)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL retire_unexpected: got 0x%0h, expected no retire", sd(3));
            end else begin
                e = sb.pop_front();
                checkOutput("retire_data", sd(3), e.data);
                checkOutput("retire_ctrl", sc(3), e.ctrl);
            end
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        tick();
        tick();
        checkOutput("reset_valid", st_valid, 0);
        checkOutput("reset_data", st_data, 0);
        checkOutput("reset_ctrl", st_ctrl, 0);
        checkOutput("reset_cnts", {stall_cnt, flush_cnt, retire_cnt}, 0);
        checkOutput("reset_ready", in_ready, 1);
        reset = 1'b0;

        // Streaming: entry 0 reaches the last stage on edge 4 and retires on edge 5.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, entry(i), 0, 0, 4'b0000, 4'b0000, 0, 0);
            if (i < 4) push_exp(entry(i));
            tick();
            if (i == 3) begin
                checkOutput("stream_s3_first", sd(3), 32'h100);
                checkOutput("stream_s3_ctrl", sc(3), ctrl_of(32'h100));
                checkOutput("stream_retire0", retire_cnt, 0);
            end
            if (i == 4) begin
                checkOutput("stream_s3_next", sd(3), 32'h104);
                checkOutput("stream_retire1", retire_cnt, 1);
            end
        end

        // Stall at stage 2: stages 0/1 hold, stage 2 bubbles, stage 3 advances.
        applyStimulus(1, entry(5), 1, 3'd2, 4'b0000, 4'b0000, 0, 0);
        #1;
        checkOutput("stall_in_ready", in_ready, 0);
        tick();
        checkOutput("stall_s0", sd(0), entry(4));
        checkOutput("stall_s1", sd(1), entry(3));
        checkOutput("stall_valid", st_valid, 4'b1011);
        checkOutput("stall_s2_data", sd(2), 0);
        checkOutput("stall_s3", sd(3), entry(2));
        checkOutput("stall_cnt1", stall_cnt, 1);
        checkOutput("stall_retire2", retire_cnt, 2);

        // Flush stages 0 and 1; the old stage-1 entry still moves into stage 2.
        applyStimulus(1, entry(5), 0, 0, 4'b0011, 4'b0000, 0, 0);
        #1;
        checkOutput("flush_in_ready", in_ready, 1);
        tick();
        checkOutput("flush_valid", st_valid, 4'b0100);
        checkOutput("flush_s2", sd(2), entry(3));
        checkOutput("flush_s0_data", sd(0), 0);
        checkOutput("flush_s0_ctrl", sc(0), 0);
        checkOutput("flush_s1_ctrl", sc(1), 0);
        checkOutput("flush_cnt1", flush_cnt, 1);
        checkOutput("flush_retire3", retire_cnt, 3);

        // Result update: stage-1 payload replaced as it advances into stage 2.
        applyStimulus(1, entry(6), 0, 0, 4'b0000, 4'b0000, 0, 0);
        tick();
        applyStimulus(1, entry(7), 0, 0, 4'b0000, 4'b0000, 0, 0);
        push_exp(entry(7));
        tick();
        applyStimulus(1, entry(8), 0, 0, 4'b0000, 4'b0010, 32'hDEADBEEF, 0);
        push_exp(entry(8));
        tick();
        checkOutput("upd_s2_data", sd(2), 32'hDEADBEEF);
        checkOutput("upd_s2_ctrl", sc(2), ctrl_of(entry(6)));
        checkOutput("upd_s1_kept", sd(1), entry(7));
        checkOutput("upd_valid", st_valid, 4'b0111);
        checkOutput("upd_retire4", retire_cnt, 4);

        // Freeze with a last-stage flush; a pending update must not apply.
        applyStimulus(1, entry(9), 0, 0, 4'b0000, 4'b0000, 0, 0);
        push_exp(entry(9));
        tick();
        checkOutput("pre_freeze_s3", sd(3), 32'hDEADBEEF);
        applyStimulus(1, entry(10), 1, 3'd4, 4'b1000, 4'b0010, 32'h12345678, 0);
        tick();
        checkOutput("freeze_valid", st_valid, 4'b0111);
        checkOutput("freeze_s0", sd(0), entry(9));
        checkOutput("freeze_s1", sd(1), entry(8));
        checkOutput("freeze_s2", sd(2), entry(7));
        checkOutput("freeze_s3_data", sd(3), 0);
        checkOutput("freeze_s3_ctrl", sc(3), 0);
        checkOutput("freeze_retire", retire_cnt, 4);
        checkOutput("freeze_stall_cnt", stall_cnt, 2);
        checkOutput("freeze_flush_cnt", flush_cnt, 2);

        // Stream until the 4-bit retire counter wraps from 15 to 0.
        for (int m = 13; m <= 25; m++) begin
            applyStimulus(1, entry(m - 3), 0, 0, 4'b0000, 4'b0000, 0, 0);
            if (m - 3 <= 20) push_exp(entry(m - 3));
            tick();
            if (m == 24) checkOutput("wrap_retire_max", retire_cnt, 4'hF);
            if (m == 25) checkOutput("wrap_retire_zero", retire_cnt, 0);
        end

        // Clear coincides with a retire: clear wins.
        applyStimulus(1, entry(23), 0, 0, 4'b0000, 4'b0000, 0, 1);
        tick();
        checkOutput("clr_retire", retire_cnt, 0);
        checkOutput("clr_stall", stall_cnt, 0);
        checkOutput("clr_flush", flush_cnt, 0);
        applyStimulus(1, entry(24), 0, 0, 4'b0000, 4'b0000, 0, 0);
        tick();
        checkOutput("post_clr_retire", retire_cnt, 1);

        // Mid-cycle asynchronous reset empties the chain and counters immediately.
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", st_valid, 0);
        checkOutput("async_data", st_data, 0);
        checkOutput("async_ctrl", st_ctrl, 0);
        checkOutput("async_retire", retire_cnt, 0);
        checkOutput("sb_drained", sb.size(), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
